matrix_grad_backprop: RTL and testbench
=======================================

# matrix_grad_backprop

Sequential backward-pass engine for the neural-net datapath. It computes the input gradient of a dense layer, `grad_a = grad_out × Bᵀ`, which is the reverse direction of the forward matrix dot product. It sits after the loss/activation-derivative stage and feeds the gradient of the previous layer. It uses one multiply-accumulate per cycle over signed fixed-point operands, and inputs are captured on a start handshake.

## Interface
- `M`, default 2: rows of `grad_out` and `grad_a`.
- `N`, default 2: columns of `grad_out` and columns of `B`. This is the reduction length.
- `K`, default 2: rows of `B` and columns of `grad_a`.
- `W`, default 16: operand and result width, two's complement.
- `FRAC`, default 8: fractional bits (Q(W-FRAC).FRAC). Must satisfy 1 ≤ FRAC < W.

Ports:
- `clk`, input, 1: sole clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: start request. Sampled only in IDLE.
- `grad_out`, input, M*N*W: element (r,c) is at bits `[(r*N+c)*W +: W]`.
- `matrix_b`, input, K*N*W: element (r,c) is at bits `[(r*N+c)*W +: W]`.
- `busy`, output, 1: high while computing.
- `done`, output, 1: one-cycle pulse when the result is valid.
- `grad_a`, output, M*K*W: element (i,j) is at bits `[(i*K+j)*W +: W]`. Holds its value between jobs.

## Operation
- `grad_a[i][j] = Σ_{k=0..N-1} grad_out[i][k] * matrix_b[j][k]`.
- **IDLE:**
  - `enable=1` at a clock edge latches `grad_out` and `matrix_b` into internal registers.
  - Indices i, j, k and the accumulator are cleared.
  - State goes to RUN.
- **RUN:**
  - One product per cycle, `p = g[i][k] * b[j][k]`, full 2W-bit signed.
  - Accumulator width is 2W + clog2(N) + 1. No intermediate overflow is possible.
  - When k < N-1: `acc += p`, then k++.
  - When k == N-1:
    - Finalise `s = acc + p`.
    - Round half-up: `r = (s + 2^(FRAC-1)) >>> FRAC` (arithmetic shift).
    - Saturate r to [-2^(W-1), 2^(W-1)-1].
    - Write r into result buffer element (i,j), clear acc, set k=0.
    - Advance j. On wrap, j=0 and i++.
  - After element (M-1,K-1) is written, state goes to DONE.
- **DONE (one cycle):**
  - The result buffer is copied to `grad_a`, so all elements update together.
  - `done=1`, `busy=0`. State goes to IDLE.
- Inputs may change freely after the accept edge. Only the latched copies are used.
- `enable` in RUN or DONE is ignored. It is not queued.
- Reset in any state:
  - Returns to IDLE and aborts the job.
  - `busy=0`, `done=0`, `grad_a=0`, internal buffers = 0.

## Timing
- Reset values: `busy=0`, `done=0`, `grad_a` all zero, state IDLE.
- Edge numbering: the accept edge (IDLE with `enable=1`) is edge 0.
- After edge 0: `busy=1`.
- During the M*K*N cycles of RUN: `busy=1`.
- After edge M*K*N: `busy=0` and `done=1`, and `grad_a` shows the new result in that cycle.
- After edge M*K*N+1: `done=0` and state is IDLE. A new `enable` at this edge is accepted.
- Minimum job-to-job period: M*K*N+1 cycles. For the defaults this is 9.
- `done` is registered and pulses exactly once per accepted job. It is never asserted after an aborted job.
- `grad_a` changes only in the DONE cycle or on reset.

## Test plan
1. **Identity.** Defaults. Set `grad_out`=[[1,2],[3,4]] (raw 256,512,768,1024) and `matrix_b`=I (256,0,0,256). Pulse `enable` → `done` at edge 8 (cycle 9). `grad_a` raw = 256,512,768,1024. `busy` is high for exactly 8 cycles.
2. **General.** Set `grad_out`=[[1,2],[3,4]] and `matrix_b`=[[5,6],[7,8]] → `grad_a`=[[17,23],[39,53]], raw 4352,5888,9984,13568.
3. **Saturation.** All `grad_out`=100.0 (25600) and all `matrix_b`=100.0 → all `grad_a`=32767. Negate `matrix_b` → all `grad_a`=-32768.
4. **Rounding.**
   - `grad_out[0][0]`=raw 1, `matrix_b[0][0]`=raw 128, others 0 → `grad_a[0][0]`=1, others 0.
   - `grad_out[0][0]`=raw -1 with the same `matrix_b` → `grad_a[0][0]`=0 (half rounds up).
5. **Busy handling.**
   - Start the job of test 2. Hold `enable=1` continuously and change the inputs to zeros after the accept edge.
   - The first result equals that of test 2.
   - The second job starts at the edge after `done`, with zero inputs → zero result, `done` 9 cycles later.
   - `done` pulses once per job.
6. **Reset mid-job.**
   - Reset at edge 4 of a job → `busy`=0, `grad_a`=0, and no `done` ever appears for that job.
   - Then run test 2 → correct result with normal latency.

Source files
------------

// File: rtl/matrix_grad_backprop.sv
// ============================================================================
// Module   : matrix_grad_backprop
// Purpose  : Sequential grad_a = grad_out x B^T, one signed fixed-point MAC/cycle
// Revision : 1.0
// ============================================================================
`default_nettype none

module matrix_grad_backprop #(
  parameter int M    = 2,
  parameter int N    = 2,
  parameter int K    = 2,
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [M*N*W-1:0] grad_out,
  input  logic [K*N*W-1:0] matrix_b,
  output logic             busy,
  output logic             done,
  output logic [M*K*W-1:0] grad_a
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (K > 1) ? $clog2(K) : 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = 2 * W + $clog2(N) + 1;

  localparam logic [IW-1:0] c_i_last = IW'(M - 1);
  localparam logic [JW-1:0] c_j_last = JW'(K - 1);
  localparam logic [KW-1:0] c_k_last = KW'(N - 1);

  localparam logic signed [AW-1:0] c_half = AW'(64'd1 << (FRAC - 1));
  localparam logic signed [AW-1:0] c_max  = AW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] c_min  = ~c_max;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  logic signed [W-1:0]    r_g   [M][N];
  logic signed [W-1:0]    r_b   [K][N];
  logic signed [W-1:0]    r_res [M][K];
  logic [IW-1:0]          r_i;
  logic [JW-1:0]          r_j;
  logic [KW-1:0]          r_k;
  logic signed [AW-1:0]   r_acc;

  logic signed [W-1:0]    w_gsel;
  logic signed [W-1:0]    w_bsel;
  logic signed [2*W-1:0]  w_prod;
  logic signed [AW-1:0]   w_sum;
  logic signed [AW-1:0]   w_shift;
  logic signed [W-1:0]    w_sat;
  logic signed [W-1:0]    w_res_next [M][K];
  logic [M*K*W-1:0]       w_packed;
  logic                   w_k_last;
  logic                   w_last_elem;

  assign w_gsel  = r_g[r_i][r_k];
  assign w_bsel  = r_b[r_j][r_k];
  assign w_prod  = (2 * W)'(w_gsel) * (2 * W)'(w_bsel);
  assign w_sum   = r_acc + AW'(w_prod);
  // Round half toward +inf, then arithmetic shift back to Q format
  assign w_shift = (w_sum + c_half) >>> FRAC;
  assign w_sat   = (w_shift > c_max) ? c_max[W-1:0] :
                   (w_shift < c_min) ? c_min[W-1:0] : w_shift[W-1:0];

  assign w_k_last    = (r_k == c_k_last);
  assign w_last_elem = w_k_last && (r_j == c_j_last) && (r_i == c_i_last);

  always_comb begin
    w_res_next = r_res;
    w_res_next[r_i][r_j] = w_sat;
  end

  for (genvar gi = 0; gi < M; gi++) begin : g_pack_row
    for (genvar gj = 0; gj < K; gj++) begin : g_pack_col
      assign w_packed[(gi*K+gj)*W +: W] = w_res_next[gi][gj];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      grad_a  <= '0;
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < N; c++) r_g[r][c] <= '0;
        for (int c = 0; c < K; c++) r_res[r][c] <= '0;
      end
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < N; c++) r_b[r][c] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            for (int r = 0; r < M; r++) begin
              for (int c = 0; c < N; c++) r_g[r][c] <= grad_out[(r*N+c)*W +: W];
            end
            for (int r = 0; r < K; r++) begin
              for (int c = 0; c < N; c++) r_b[r][c] <= matrix_b[(r*N+c)*W +: W];
            end
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!w_k_last) begin
            r_acc <= w_sum;
            r_k   <= r_k + KW'(1);
          end else begin
            r_res <= w_res_next;
            r_acc <= '0;
            r_k   <= '0;
            if (r_j == c_j_last) begin
              r_j <= '0;
              r_i <= r_i + IW'(1);
            end else begin
              r_j <= r_j + JW'(1);
            end
            // The done cycle doubles as idle so back-to-back jobs need no gap
            if (w_last_elem) begin
              grad_a  <= w_packed;
              done    <= 1'b1;
              busy    <= 1'b0;
              r_i     <= '0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matrix_grad_backprop.sv
// ============================================================================
// Module   : tb_matrix_grad_backprop
// Purpose  : Directed and random checks of matrix_grad_backprop (defaults)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_matrix_grad_backprop;

  localparam int M = 2, N = 2, K = 2, W = 16, FRAC = 8;
  localparam int LAT = M * K * N;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [M*N*W-1:0] grad_out;
  logic [K*N*W-1:0] matrix_b;
  logic             busy;
  logic             done;
  logic [M*K*W-1:0] grad_a;

  int total = 0;
  int bad   = 0;

  matrix_grad_backprop #(.M(M), .N(N), .K(K), .W(W), .FRAC(FRAC)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .grad_out (grad_out),
    .matrix_b (matrix_b),
    .busy     (busy),
    .done     (done),
    .grad_a   (grad_a)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    logic [15:0] x0, x1, x2, x3;
    x0 = 16'(a); x1 = 16'(b); x2 = 16'(c); x3 = 16'(d);
    return {x3, x2, x1, x0};
  endfunction

  // Reference: plain integer dot products, round half-up, clamp to W bits
  function automatic logic [M*K*W-1:0] model(input logic [M*N*W-1:0] go, input logic [K*N*W-1:0] bm);
    logic [M*K*W-1:0] res;
    longint s, r;
    res = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < K; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += longint'($signed(go[(i*N+k)*W +: W])) * longint'($signed(bm[(j*N+k)*W +: W]));
        r = (s + (longint'(1) << (FRAC - 1))) >>> FRAC;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        res[(i*K+j)*W +: W] = 16'(r);
      end
    end
    return res;
  endfunction

  // Accept, scramble inputs, wait for done; checks latency, busy span and result
  task automatic run_job(input string tag, input logic [63:0] g, input logic [63:0] b,
                         input logic [63:0] exp);
    int cyc, busy_cnt;
    grad_out = g;
    matrix_b = b;
    enable   = 1'b1;
    tick();
    enable   = 1'b0;
    grad_out = {$urandom, $urandom};
    matrix_b = {$urandom, $urandom};
    cyc = 0;
    busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(LAT));
    chk({tag, "_busycnt"}, 64'(busy_cnt), 64'(LAT));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_result"}, grad_a, exp);
    tick();
    chk({tag, "_done_drop"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [63:0] g2, b2, e2, g, b;
    int cyc, pulses;

    reset = 1'b1; enable = 1'b0; grad_out = '0; matrix_b = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_grad_a", grad_a, 64'd0);

    g2 = pack4(256, 512, 768, 1024);
    b2 = pack4(1280, 1536, 1792, 2048);
    e2 = pack4(4352, 5888, 9984, 13568);

    run_job("identity", g2, pack4(256, 0, 0, 256), pack4(256, 512, 768, 1024));
    run_job("general", g2, b2, e2);
    chk("general_model", model(g2, b2), e2);
    run_job("sat_pos", pack4(25600, 25600, 25600, 25600), pack4(25600, 25600, 25600, 25600),
            pack4(32767, 32767, 32767, 32767));
    run_job("sat_neg", pack4(25600, 25600, 25600, 25600), pack4(-25600, -25600, -25600, -25600),
            pack4(-32768, -32768, -32768, -32768));
    run_job("round_pos", pack4(1, 0, 0, 0), pack4(128, 0, 0, 0), pack4(1, 0, 0, 0));
    run_job("round_neg", pack4(-1, 0, 0, 0), pack4(128, 0, 0, 0), pack4(0, 0, 0, 0));

    // enable held high across two jobs; inputs zeroed after first accept
    grad_out = g2; matrix_b = b2; enable = 1'b1;
    tick();
    grad_out = '0; matrix_b = '0;
    cyc = 0; pulses = 0;
    while (!done && cyc < 40) begin tick(); cyc++; end
    chk("held_lat1", 64'(cyc), 64'(LAT));
    chk("held_res1", grad_a, e2);
    pulses = 1;
    tick();
    chk("held_restart_busy", 64'(busy), 64'd1);
    chk("held_restart_done", 64'(done), 64'd0);
    cyc = 1;
    while (!done && cyc < 40) begin tick(); cyc++; end
    chk("held_lat2", 64'(cyc), 64'(LAT + 1));
    chk("held_res2", grad_a, 64'd0);
    enable = 1'b0;
    for (int t = 0; t < 12; t++) begin tick(); if (done) pulses++; end
    chk("held_pulses", 64'(pulses), 64'd1);

    // reset sampled at edge 4 of a job
    grad_out = g2; matrix_b = b2; enable = 1'b1;
    tick();
    enable = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_grad_a", grad_a, 64'd0);
    pulses = 0;
    for (int t = 0; t < 15; t++) begin if (done) pulses++; tick(); end
    chk("abort_no_done", 64'(pulses), 64'd0);
    run_job("after_abort", g2, b2, e2);

    for (int n = 0; n < 20; n++) begin
      g = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (n < 10) begin
        for (int e = 0; e < 4; e++) begin
          g[e*16 +: 16] = 16'($signed(g[e*16 +: 16]) >>> 4);
          b[e*16 +: 16] = 16'($signed(b[e*16 +: 16]) >>> 4);
        end
      end
      run_job($sformatf("rand%0d", n), g, b, model(g, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
